// File: rtl/l2_cache_arbiter.sv
// l2_cache_arbiter
// Shares one unified L2 port between the I-cache and D-cache miss interfaces.
// A requester is granted from IDLE with round-robin fairness. Its address and
// write data are latched, and the L2 request is held until l2_resp. The
// completion goes back to the granted requester only.
// Optional build macro: L2_ARB_PERF_CNT_EN adds saturating grant and
// conflict counters as extra outputs.
module l2_cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_resp
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       i_grant_cnt,
  output logic [31:0]       d_grant_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t state;
  logic   last_served_d;
  logic   i_req;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;
  logic   conflict;

  // Decode requests and pick a winner; on a tie the one not served last wins
  always_comb begin
    i_req    = i_read;
    d_req    = d_read | d_write;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    conflict = 1'b0;
    case (state)
      IDLE: begin
        grant_i  = i_req & (~d_req | last_served_d);
        grant_d  = d_req & (~i_req | ~last_served_d);
        conflict = i_req & d_req;
      end
      SERVE_I: conflict = d_req;
      SERVE_D: conflict = i_req;
      default: conflict = 1'b0;
    endcase
  end

  // Arbitration FSM: latch the winner, hold the L2 request until l2_resp
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_served_d <= 1'b1;
      l2_read       <= 1'b0;
      l2_write      <= 1'b0;
      l2_address    <= '0;
      l2_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state         <= SERVE_I;
            last_served_d <= 1'b0;
            l2_read       <= 1'b1;
            l2_write      <= 1'b0;
            l2_address    <= i_address;
          end else if (grant_d) begin
            state         <= SERVE_D;
            last_served_d <= 1'b1;
            l2_read       <= ~d_write;
            l2_write      <= d_write;
            l2_address    <= d_address;
            l2_wdata      <= d_wdata;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            state    <= IDLE;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion is routed only to the requester being served, never during reset
  always_comb begin
    i_resp  = rst_n & l2_resp & (state == SERVE_I);
    d_resp  = rst_n & l2_resp & (state == SERVE_D);
    i_rdata = l2_rdata;
    d_rdata = l2_rdata;
  end

`ifdef L2_ARB_PERF_CNT_EN
  // Saturating grant and conflict counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_i && i_grant_cnt != 32'hFFFF_FFFF) begin
        i_grant_cnt <= i_grant_cnt + 32'd1;
      end
      if (!grant_i && grant_d && d_grant_cnt != 32'hFFFF_FFFF) begin
        d_grant_cnt <= d_grant_cnt + 32'd1;
      end
      if (conflict && conflict_cnt != 32'hFFFF_FFFF) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
